// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline freeze/stall/flush sequencer:
// sequencer state encoding and the default drain length.
package pipeline_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_HALTED    = 3'd4
  } pcu_state_e;

  // Advancing cycles needed after HALT leaves ID to empty EX, MEM and WB.
  localparam int DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/pipeline_control_unit_stall_counter.sv
// Saturating up-counter with synchronous clear; counts load-use stall
// cycles for the debug unit and holds at all-ones.
module stall_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      o_count <= '0;
    end else if (i_en && (o_count != '1)) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Central freeze/stall/flush sequencer for the 5-stage MIPS pipeline, with
// debug run/step control, HALT drain, and cycle/stall counters.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int LEN          = 32,
  parameter int NB_CNT       = 16,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic              i_step,
  input  logic              i_stall_flag,
  input  logic              i_branch_taken,
  input  logic              i_halt,
  output logic              o_pipe_en,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_if_id_flush,
  output logic              o_id_ex_bubble,
  output logic              o_halted,
  output logic [LEN-1:0]    o_cycle_count,
  output logic [NB_CNT-1:0] o_stall_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  pcu_state_e         state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               pipe_en;
  logic               pc_write;
  logic               if_id_write;
  logic               if_id_flush;
  logic               id_ex_bubble;
  logic               halt_take;
  logic               stall_take;
  logic               start_take;

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    pipe_en      = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halt_take    = 1'b0;
    stall_take   = 1'b0;
    unique case (state)
      ST_RUN, ST_STEP_WAIT: begin
        pipe_en = (state == ST_RUN) || i_step;
        if (pipe_en) begin
          // HALT has no operands, so a coincident load-use flag is spurious;
          // a stalled branch has stale operands, so its redirect waits.
          if (i_halt) begin
            halt_take    = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (i_stall_flag) begin
            stall_take   = 1'b1;
            id_ex_bubble = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = i_branch_taken;
          end
        end
      end
      ST_DRAIN: begin
        pipe_en      = 1'b1;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign start_take     = (state == ST_IDLE) && i_start;
  assign o_pipe_en      = pipe_en;
  assign o_pc_write     = pc_write;
  assign o_if_id_write  = if_id_write;
  assign o_if_id_flush  = if_id_flush;
  assign o_id_ex_bubble = id_ex_bubble;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      drain_cnt     <= '0;
      o_halted      <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      if (pipe_en) begin
        o_cycle_count <= o_cycle_count + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            state         <= i_step_mode ? ST_STEP_WAIT : ST_RUN;
            o_cycle_count <= '0;
          end
        end
        ST_RUN, ST_STEP_WAIT: begin
          if (halt_take) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state    <= ST_HALTED;
            o_halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_HALTED: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  stall_counter #(
    .WIDTH (NB_CNT)
  ) u_stall_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (start_take),
    .i_en    (stall_take),
    .o_count (o_stall_count)
  );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit: a directed vector table,
// hand-written multi-cycle sequences, and randomized traffic vs. a model.
module tb_pipeline_control_unit;

  localparam int LEN    = 32;
  localparam int NB_CNT = 4;
  localparam int DRAIN  = 3;
  localparam int SAT    = (1 << NB_CNT) - 1;

  typedef struct packed {
    logic reset, start, step_mode, step, stall, branch, halt;
  } in_t;

  typedef struct packed {
    logic pipe_en, pc_write, if_id_write, flush, bubble, halted;
    logic [LEN-1:0]    cyc;
    logic [NB_CNT-1:0] stl;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic i_reset, i_start, i_step_mode, i_step, i_stall_flag, i_branch_taken, i_halt;
  logic o_pipe_en, o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted;
  logic [LEN-1:0]    o_cycle_count;
  logic [NB_CNT-1:0] o_stall_count;

  always #5 clk = ~clk;

  pipeline_control_unit #(
    .LEN          (LEN),
    .NB_CNT       (NB_CNT),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_step_mode    (i_step_mode),
    .i_step         (i_step),
    .i_stall_flag   (i_stall_flag),
    .i_branch_taken (i_branch_taken),
    .i_halt         (i_halt),
    .o_pipe_en      (o_pipe_en),
    .o_pc_write     (o_pc_write),
    .o_if_id_write  (o_if_id_write),
    .o_if_id_flush  (o_if_id_flush),
    .o_id_ex_bubble (o_id_ex_bubble),
    .o_halted       (o_halted),
    .o_cycle_count  (o_cycle_count),
    .o_stall_count  (o_stall_count)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  out_t got;

  // Reference model: run/step flags, remaining drain cycles, plain counters.
  bit     m_valid    = 1'b0;
  bit     m_started  = 1'b0;
  bit     m_stepmode = 1'b0;
  bit     m_halted   = 1'b0;
  int     m_drain    = 0;
  longint m_cycles   = 0;
  int     m_stalls   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_adv(input in_t v);
    if (m_halted)  return 1'b0;
    if (m_drain > 0) return 1'b1;
    if (m_started) return m_stepmode ? v.step : 1'b1;
    return 1'b0;
  endfunction

  function automatic out_t model_out(input in_t v);
    out_t o;
    o = '0;
    if (model_adv(v)) begin
      o.pipe_en = 1'b1;
      if (m_drain > 0 || v.halt || v.stall) begin
        o.bubble = 1'b1;
      end else begin
        o.pc_write    = 1'b1;
        o.if_id_write = 1'b1;
        o.flush       = v.branch;
      end
    end
    o.halted = m_halted;
    o.cyc    = m_cycles[LEN-1:0];
    o.stl    = m_stalls[NB_CNT-1:0];
    return o;
  endfunction

  task automatic model_next(input in_t v);
    bit adv;
    adv = model_adv(v);
    if (v.reset) begin
      m_valid = 1'b1; m_started = 1'b0; m_stepmode = 1'b0; m_halted = 1'b0;
      m_drain = 0; m_cycles = 0; m_stalls = 0;
    end else if (!m_started && !m_halted && m_drain == 0) begin
      if (v.start) begin
        m_started = 1'b1; m_stepmode = v.step_mode; m_cycles = 0; m_stalls = 0;
      end
    end else begin
      if (adv) m_cycles = (m_cycles + 1) % (64'd1 << LEN);
      if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_halted = 1'b1;
      end else if (adv && v.halt) begin
        m_drain = DRAIN; m_started = 1'b0;
      end else if (adv && v.stall) begin
        if (m_stalls < SAT) m_stalls++;
      end
    end
  endtask

  // Drive one cycle of inputs, sample outputs mid-cycle, compare to the model.
  task automatic apply(input in_t v);
    out_t e;
    @(posedge clk);
    #1;
    i_reset = v.reset; i_start = v.start; i_step_mode = v.step_mode; i_step = v.step;
    i_stall_flag = v.stall; i_branch_taken = v.branch; i_halt = v.halt;
    #2;
    got = {o_pipe_en, o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble,
           o_halted, o_cycle_count, o_stall_count};
    if (m_valid) begin
      e = model_out(v);
      check("m_pipe_en",  64'(got.pipe_en),     64'(e.pipe_en));
      check("m_pc_write", 64'(got.pc_write),    64'(e.pc_write));
      check("m_if_id_wr", 64'(got.if_id_write), 64'(e.if_id_write));
      check("m_flush",    64'(got.flush),       64'(e.flush));
      check("m_bubble",   64'(got.bubble),      64'(e.bubble));
      check("m_halted",   64'(got.halted),      64'(e.halted));
      check("m_cycles",   64'(got.cyc),         64'(e.cyc));
      check("m_stalls",   64'(got.stl),         64'(e.stl));
    end
    model_next(v);
  endtask

  function automatic vec_t mkv(input logic [6:0] i, input logic [5:0] o, input int cyc, input int stl);
    vec_t r;
    r.i = in_t'(i);
    r.o = {o, LEN'(cyc), NB_CNT'(stl)};
    return r;
  endfunction

  // Input bit order: reset start step_mode step stall branch halt
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] RST   = 7'b1000000;
  localparam logic [6:0] START = 7'b0100000;
  localparam logic [6:0] STRTS = 7'b0110000;
  localparam logic [6:0] STEP  = 7'b0001000;
  localparam logic [6:0] STALL = 7'b0000100;
  localparam logic [6:0] HALT  = 7'b0000001;

  vec_t table_v[13];

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
    i_stall_flag = 1'b0; i_branch_taken = 1'b0; i_halt = 1'b0;

    // Reset state
    apply(in_t'(RST));
    apply(in_t'(RST));
    check("reset_pipe_en", 64'(got.pipe_en), 64'(0));
    check("reset_halted",  64'(got.halted),  64'(0));
    check("reset_cycles",  64'(got.cyc),     64'(0));
    check("reset_stalls",  64'(got.stl),     64'(0));

    // Output bit order: pipe_en pc_write if_id_write flush bubble halted
    table_v[0]  = mkv(START,       6'b000000, 0, 0);
    table_v[1]  = mkv(NONE,        6'b111000, 0, 0);
    table_v[2]  = mkv(STALL,       6'b100010, 1, 0);
    table_v[3]  = mkv(7'b0000110,  6'b100010, 2, 1);
    table_v[4]  = mkv(7'b0000010,  6'b111100, 3, 2);
    table_v[5]  = mkv(7'b0000101,  6'b100010, 4, 2);
    table_v[6]  = mkv(7'b0000010,  6'b100010, 5, 2);
    table_v[7]  = mkv(STALL,       6'b100010, 6, 2);
    table_v[8]  = mkv(NONE,        6'b100010, 7, 2);
    table_v[9]  = mkv(START,       6'b000001, 8, 2);
    table_v[10] = mkv(STEP,        6'b000001, 8, 2);
    table_v[11] = mkv(RST,         6'b000001, 8, 2);
    table_v[12] = mkv(NONE,        6'b000000, 0, 0);
    for (int r = 0; r < 13; r++) begin
      apply(table_v[r].i);
      check($sformatf("row%0d_ctrl", r),   64'(got[LEN+NB_CNT+5:LEN+NB_CNT]),
            64'(table_v[r].o[LEN+NB_CNT+5:LEN+NB_CNT]));
      check($sformatf("row%0d_cycles", r), 64'(got.cyc), 64'(table_v[r].o.cyc));
      check($sformatf("row%0d_stalls", r), 64'(got.stl), 64'(table_v[r].o.stl));
    end

    // Step mode: no steps means frozen; three steps give three cycles
    apply(in_t'(STRTS));
    for (int k = 0; k < 20; k++) apply(in_t'(NONE));
    check("step_idle_cycles",  64'(got.cyc),     64'(0));
    check("step_idle_pipe_en", 64'(got.pipe_en), 64'(0));
    for (int k = 0; k < 3; k++) begin
      apply(in_t'(STEP));
      apply(in_t'(NONE));
    end
    check("step_three_cycles", 64'(got.cyc), 64'(3));
    // A stalled step is consumed; the next step re-evaluates the stall
    apply(in_t'(STEP | STALL));
    check("step_stall_bubble", 64'(got.bubble),   64'(1));
    check("step_stall_pc",     64'(got.pc_write), 64'(0));
    apply(in_t'(NONE));
    check("step_after_stall_pc", 64'(got.pc_write), 64'(0));
    apply(in_t'(STEP | STALL));
    check("step_stall2_bubble", 64'(got.bubble), 64'(1));
    apply(in_t'(NONE));
    check("step_stall_count", 64'(got.stl), 64'(2));

    // HALT latency from step mode, then start/step ignored while halted
    apply(in_t'(RST));
    apply(in_t'(STRTS));
    apply(in_t'(NONE));
    apply(in_t'(STEP | HALT | STALL));
    check("halt_bubble", 64'(got.bubble),   64'(1));
    check("halt_pc",     64'(got.pc_write), 64'(0));
    for (int k = 1; k <= DRAIN; k++) begin
      apply(in_t'(NONE));
      check($sformatf("drain%0d_pipe_en", k), 64'(got.pipe_en), 64'(1));
      check($sformatf("drain%0d_halted", k),  64'(got.halted),  64'(0));
    end
    apply(in_t'(NONE));
    check("halted_at_n4", 64'(got.halted), 64'(1));
    apply(in_t'(START));
    apply(in_t'(STEP));
    check("halted_step_ignored", 64'(got.pipe_en), 64'(0));
    apply(in_t'(NONE));
    check("halted_cycles", 64'(got.cyc), 64'(1 + DRAIN));

    // Reset during DRAIN
    apply(in_t'(RST));
    apply(in_t'(START));
    apply(in_t'(NONE));
    apply(in_t'(STALL));
    apply(in_t'(HALT));
    apply(in_t'(NONE));
    apply(in_t'(RST));
    apply(in_t'(NONE));
    check("drain_rst_pipe_en", 64'(got.pipe_en), 64'(0));
    check("drain_rst_halted",  64'(got.halted),  64'(0));
    check("drain_rst_cycles",  64'(got.cyc),     64'(0));
    check("drain_rst_stalls",  64'(got.stl),     64'(0));

    // Stall counter saturation
    apply(in_t'(START));
    for (int k = 0; k < 20; k++) apply(in_t'(STALL));
    apply(in_t'(NONE));
    check("stall_saturate", 64'(got.stl), 64'(SAT));
    check("stall_sat_cycles", 64'(got.cyc), 64'(20));

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      in_t v;
      v.reset     = ($urandom_range(0, 99) == 0);
      v.start     = ($urandom_range(0, 3) == 0);
      v.step_mode = $urandom_range(0, 1);
      v.step      = $urandom_range(0, 1);
      v.stall     = ($urandom_range(0, 3) == 0);
      v.branch    = ($urandom_range(0, 3) == 0);
      v.halt      = ($urandom_range(0, 39) == 0);
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
